// File: rtl/uart_rx_fifo.sv
// Receive-side buffer: drives the UART receiver go/ack handshake and stores bytes in a FWFT FIFO.
// Optional macro UART_RX_FIFO_DROP_EN: keep re-arming while full, discard bytes and raise sticky overrun.
`timescale 1ns/1ps
module uart_rx_fifo #(
    parameter int DepthLog2 = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [7:0]           urx_data,
    input  logic                 urx_data_ready,
    output logic                 urx_go,
    input  logic                 rd_en,
    output logic [7:0]           rd_data,
    output logic                 empty,
    output logic                 full,
    output logic [DepthLog2:0]   count,
    output logic                 overrun,
    input  logic                 clr_overrun
);

    localparam int DEPTH = 1 << DepthLog2;
    localparam logic [DepthLog2:0] FULL_COUNT = (DepthLog2 + 1)'(DEPTH);
`ifdef UART_RX_FIFO_DROP_EN
    localparam bit DROP_EN = 1'b1;
`else
    localparam bit DROP_EN = 1'b0;
`endif

    typedef enum logic [1:0] {INIT, ARM, ACK, HOLD} state_t;

    state_t                 state_reg;
    state_t                 state_next;

    logic [7:0]             mem [DEPTH];
    logic [DepthLog2-1:0]   wr_ptr_reg;
    logic [DepthLog2-1:0]   wr_ptr_next;
    logic [DepthLog2-1:0]   rd_ptr_reg;
    logic [DepthLog2-1:0]   rd_ptr_next;
    logic [DepthLog2:0]     count_reg;
    logic [DepthLog2:0]     count_next;
    logic [7:0]             rd_data_reg;
    logic                   overrun_reg;
    logic                   overrun_next;

    logic                   full_int;
    logic                   empty_int;
    logic                   pop;
    logic                   full_after_pop;
    logic                   capture;
    logic                   wr_en;
    logic                   drop;

    // Flags come only from the registered count, never straight from inputs.
    assign full_int       = (count_reg == FULL_COUNT);
    assign empty_int      = (count_reg == '0);
    assign pop            = rd_en && !empty_int;
    assign full_after_pop = full_int && !pop;

    // ---------------- handshake FSM: state register ----------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg <= INIT;
        end else begin
            state_reg <= state_next;
        end
    end

    // ---------------- handshake FSM: next state ----------------
    always_comb begin
        state_next = state_reg;
        unique case (state_reg)
            INIT: state_next = ARM;
            ARM: begin
                if (urx_data_ready) begin
                    state_next = ACK;
                end
            end
            ACK: begin
                if (!urx_data_ready) begin
                    state_next = (full_after_pop && !DROP_EN) ? HOLD : ARM;
                end
            end
            HOLD: begin
                if (!full_int) begin
                    state_next = ARM;
                end
            end
            default: state_next = INIT;
        endcase
    end

    // ---------------- handshake FSM: outputs ----------------
    always_comb begin
        urx_go  = (state_reg == ARM);
        capture = (state_reg == ARM) && urx_data_ready;
        // A full FIFO still accepts a byte when the head is popped in the same cycle.
        wr_en   = capture && !full_after_pop;
        drop    = capture && full_after_pop;
    end

    // ---------------- pointer / count / overrun next values ----------------
    always_comb begin
        wr_ptr_next = wr_en ? wr_ptr_reg + DepthLog2'(1) : wr_ptr_reg;
        rd_ptr_next = pop   ? rd_ptr_reg + DepthLog2'(1) : rd_ptr_reg;
        count_next  = count_reg;
        if (wr_en && !pop) begin
            count_next = count_reg + (DepthLog2 + 1)'(1);
        end else if (pop && !wr_en) begin
            count_next = count_reg - (DepthLog2 + 1)'(1);
        end
        // Set beats clear when a drop coincides with clr_overrun.
        overrun_next = (DROP_EN && drop) || (overrun_reg && !clr_overrun);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_reg  <= '0;
            rd_ptr_reg  <= '0;
            count_reg   <= '0;
            overrun_reg <= 1'b0;
        end else begin
            wr_ptr_reg  <= wr_ptr_next;
            rd_ptr_reg  <= rd_ptr_next;
            count_reg   <= count_next;
            overrun_reg <= overrun_next;
        end
    end

    // Storage with registered read of the next head; bypass covers a write landing on that head.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr_reg] <= urx_data;
        end
        if (wr_en && (wr_ptr_reg == rd_ptr_next)) begin
            rd_data_reg <= urx_data;
        end else begin
            rd_data_reg <= mem[rd_ptr_next];
        end
    end

    assign rd_data = rd_data_reg;
    assign empty   = empty_int;
    assign full    = full_int;
    assign count   = count_reg;
    assign overrun = overrun_reg;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed self-checking bench for uart_rx_fifo with a simple receiver handshake model.
`timescale 1ns/1ps
module tb_uart_rx_fifo;

    localparam int DL2   = 4;
    localparam int DEPTH = 1 << DL2;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic [7:0]     urx_data = 8'h00;
    logic           urx_data_ready = 1'b0;
    logic           urx_go;
    logic           rd_en = 1'b0;
    logic [7:0]     rd_data;
    logic           empty;
    logic           full;
    logic [DL2:0]   count;
    logic           overrun;
    logic           clr_overrun = 1'b0;

    int tests_run = 0;
    int tests_failed = 0;

    always #5 clk = ~clk;

    uart_rx_fifo #(.DepthLog2(DL2)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .urx_data       (urx_data),
        .urx_data_ready (urx_data_ready),
        .urx_go         (urx_go),
        .rd_en          (rd_en),
        .rd_data        (rd_data),
        .empty          (empty),
        .full           (full),
        .count          (count),
        .overrun        (overrun),
        .clr_overrun    (clr_overrun)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Receiver model: wait for go, present the byte for one edge, then drop data_ready.
    task automatic deliver(input logic [7:0] b, input logic pop);
        int n;
        n = 0;
        while (urx_go !== 1'b1 && n < 50) begin
            tick();
            n++;
        end
        tests_run++;
        if (urx_go !== 1'b1) begin
            tests_failed++;
            $display("FAIL deliver_go_timeout byte=%02h go=%b required 1", b, urx_go);
        end else begin
            urx_data       = b;
            urx_data_ready = 1'b1;
            rd_en          = pop;
            tick();
            rd_en          = 1'b0;
            urx_data_ready = 1'b0;
            $display("[TB] rx byte %02h pop=%0d count=%0d go=%b", b, pop, count, urx_go);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) tick();
        tests_run++;
        if (urx_go !== 1'b0) begin tests_failed++; $display("FAIL reset_go got=%b required=0", urx_go); end
        tests_run++;
        if (empty !== 1'b1) begin tests_failed++; $display("FAIL reset_empty got=%b required=1", empty); end
        tests_run++;
        if (count !== 5'd0) begin tests_failed++; $display("FAIL reset_count got=%0d required=0", count); end
        tests_run++;
        if (full !== 1'b0) begin tests_failed++; $display("FAIL reset_full got=%b required=0", full); end
        tests_run++;
        if (overrun !== 1'b0) begin tests_failed++; $display("FAIL reset_overrun got=%b required=0", overrun); end
        rst_n = 1'b1;
        tests_run++;
        if (urx_go !== 1'b0) begin tests_failed++; $display("FAIL release_go_early got=%b required=0", urx_go); end
        tick();
        tests_run++;
        if (urx_go !== 1'b1) begin tests_failed++; $display("FAIL release_go_one_cycle got=%b required=1", urx_go); end
        $display("[TB] reset released, go=%b", urx_go);
    endtask

    task automatic test_single();
        urx_data       = 8'h55;
        urx_data_ready = 1'b1;
        tick();
        tests_run++;
        if (urx_go !== 1'b0) begin tests_failed++; $display("FAIL single_go_ack got=%b required=0", urx_go); end
        tests_run++;
        if (count !== 5'd1) begin tests_failed++; $display("FAIL single_count got=%0d required=1", count); end
        tests_run++;
        if (rd_data !== 8'h55) begin tests_failed++; $display("FAIL single_rd_data got=%02h required=55", rd_data); end
        tests_run++;
        if (empty !== 1'b0) begin tests_failed++; $display("FAIL single_empty got=%b required=0", empty); end
        urx_data_ready = 1'b0;
        tick();
        tests_run++;
        if (urx_go !== 1'b1) begin tests_failed++; $display("FAIL single_rearm got=%b required=1", urx_go); end
        rd_en = 1'b1;
        tick();
        rd_en = 1'b0;
        tests_run++;
        if (empty !== 1'b1 || count !== 5'd0) begin
            tests_failed++;
            $display("FAIL single_pop empty=%b count=%0d required empty=1 count=0", empty, count);
        end
        $display("[TB] single byte 55 captured and popped");
    endtask

    task automatic test_fill_drain();
        logic [7:0] exp_q[$];
        int n;
        for (int i = 0; i < DEPTH; i++) deliver(8'(i), 1'b0);
        tick();
        tests_run++;
        if (full !== 1'b1 || count !== 5'd16) begin
            tests_failed++;
            $display("FAIL fill_full full=%b count=%0d required full=1 count=16", full, count);
        end
`ifdef UART_RX_FIFO_DROP_EN
        n = 0;
        while (urx_go !== 1'b1 && n < 10) begin tick(); n++; end
        tests_run++;
        if (urx_go !== 1'b1) begin tests_failed++; $display("FAIL drop_rearm got=%b required=1", urx_go); end
        deliver(8'h3C, 1'b0);
        tests_run++;
        if (overrun !== 1'b1) begin tests_failed++; $display("FAIL drop_overrun got=%b required=1", overrun); end
        tests_run++;
        if (count !== 5'd16 || rd_data !== 8'h00) begin
            tests_failed++;
            $display("FAIL drop_contents count=%0d head=%02h required count=16 head=00", count, rd_data);
        end
        clr_overrun = 1'b1;
        tick();
        clr_overrun = 1'b0;
        tests_run++;
        if (overrun !== 1'b0) begin tests_failed++; $display("FAIL clr_overrun got=%b required=0", overrun); end
        deliver(8'hA5, 1'b1);
        tests_run++;
        if (count !== 5'd16 || rd_data !== 8'h01) begin
            tests_failed++;
            $display("FAIL full_write_pop count=%0d head=%02h required count=16 head=01", count, rd_data);
        end
        for (int i = 1; i < DEPTH; i++) exp_q.push_back(8'(i));
        exp_q.push_back(8'hA5);
`else
        for (int i = 0; i < 5; i++) begin
            tick();
            tests_run++;
            if (urx_go !== 1'b0) begin tests_failed++; $display("FAIL hold_go cycle=%0d got=%b required=0", i, urx_go); end
        end
        tests_run++;
        if (rd_data !== 8'h00) begin tests_failed++; $display("FAIL hold_head got=%02h required=00", rd_data); end
        rd_en = 1'b1;
        tick();
        rd_en = 1'b0;
        tests_run++;
        if (count !== 5'd15) begin tests_failed++; $display("FAIL hold_pop_count got=%0d required=15", count); end
        n = 0;
        while (urx_go !== 1'b1 && n < 10) begin tick(); n++; end
        tests_run++;
        if (urx_go !== 1'b1) begin tests_failed++; $display("FAIL hold_release got=%b required=1", urx_go); end
        for (int i = 1; i < DEPTH; i++) exp_q.push_back(8'(i));
`endif
        while (exp_q.size() > 0) begin
            tests_run++;
            if (rd_data !== exp_q[0]) begin
                tests_failed++;
                $display("FAIL drain_order got=%02h required=%02h", rd_data, exp_q[0]);
            end
            void'(exp_q.pop_front());
            rd_en = 1'b1;
            tick();
            rd_en = 1'b0;
        end
        tests_run++;
        if (empty !== 1'b1 || count !== 5'd0) begin
            tests_failed++;
            $display("FAIL drain_empty empty=%b count=%0d required empty=1 count=0", empty, count);
        end
        rd_en = 1'b1;
        tick();
        rd_en = 1'b0;
        tests_run++;
        if (empty !== 1'b1 || count !== 5'd0) begin
            tests_failed++;
            $display("FAIL underflow empty=%b count=%0d required empty=1 count=0", empty, count);
        end
        $display("[TB] fill/drain complete");
    endtask

    task automatic test_back_to_back();
        logic [7:0] q[$];
        logic [7:0] b;
        logic       p;
        for (int i = 0; i < 40; i++) begin
            b = 8'(i * 37 + 11);
            p = (q.size() >= 12);
            if (p) begin
                tests_run++;
                if (rd_data !== q[0]) begin
                    tests_failed++;
                    $display("FAIL b2b_head idx=%0d got=%02h required=%02h", i, rd_data, q[0]);
                end
            end
            deliver(b, p);
            if (p) void'(q.pop_front());
            q.push_back(b);
            tests_run++;
            if (int'(count) != q.size()) begin
                tests_failed++;
                $display("FAIL b2b_count idx=%0d got=%0d required=%0d", i, count, q.size());
            end
        end
        while (q.size() > 0) begin
            tests_run++;
            if (rd_data !== q[0]) begin
                tests_failed++;
                $display("FAIL b2b_drain got=%02h required=%02h", rd_data, q[0]);
            end
            void'(q.pop_front());
            rd_en = 1'b1;
            tick();
            rd_en = 1'b0;
        end
        tests_run++;
        if (empty !== 1'b1) begin tests_failed++; $display("FAIL b2b_empty got=%b required=1", empty); end
        $display("[TB] back-to-back 40 bytes complete");
    endtask

    task automatic test_reset_mid();
        int n;
        for (int i = 0; i < 4; i++) deliver(8'(8'h20 + i), 1'b0);
        n = 0;
        while (urx_go !== 1'b1 && n < 50) begin tick(); n++; end
        urx_data       = 8'h24;
        urx_data_ready = 1'b1;
        tick();
        tests_run++;
        if (count !== 5'd5 || urx_go !== 1'b0) begin
            tests_failed++;
            $display("FAIL mid_pre count=%0d go=%b required count=5 go=0", count, urx_go);
        end
        rst_n = 1'b0;
        tick();
        tests_run++;
        if (count !== 5'd0 || empty !== 1'b1) begin
            tests_failed++;
            $display("FAIL mid_flush count=%0d empty=%b required count=0 empty=1", count, empty);
        end
        tests_run++;
        if (urx_go !== 1'b0 || overrun !== 1'b0) begin
            tests_failed++;
            $display("FAIL mid_go go=%b overrun=%b required go=0 overrun=0", urx_go, overrun);
        end
        urx_data_ready = 1'b0;
        rst_n = 1'b1;
        tick();
        tests_run++;
        if (urx_go !== 1'b1 || count !== 5'd0) begin
            tests_failed++;
            $display("FAIL mid_restart go=%b count=%0d required go=1 count=0", urx_go, count);
        end
        $display("[TB] reset mid-operation complete");
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_single();
        test_fill_drain();
        test_back_to_back();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/uart_rx_fifo.md
Name: uart_rx_fifo

Overview:
Receive-side buffer directly downstream of the UART receiver. Drives the receiver's go/ack handshake, captures each completed byte into a power-of-two FIFO, and presents a first-word-fall-through read port to the CPU/IO bus. Decouples CPU polling latency from line rate so back-to-back bytes at 115200+ baud are not lost.

Parameters:
DepthLog2, 4, FIFO depth = 2**DepthLog2 entries (allowed 1..8)

Ports:
clk  input  1  system clock
rst_n  input  1  active-low reset, synchronous to clk
urx_data  input  8  byte from UART receiver, valid while urx_data_ready=1
urx_data_ready  input  1  receiver has a complete byte
urx_go  output  1  arm (1) / acknowledge (0) to UART receiver
rd_en  input  1  pop head entry this cycle
rd_data  output  8  head entry (FWFT), valid when empty=0
empty  output  1  FIFO holds 0 entries
full  output  1  FIFO holds 2**DepthLog2 entries
count  output  DepthLog2+1  number of stored entries
overrun  output  1  sticky: at least one byte dropped
clr_overrun  input  1  clear overrun

Behaviour:
- One clock; reset is synchronous and active-low. All state updates on posedge clk; rst_n sampled only at posedge clk.
- Reset values: urx_go=0, empty=1, full=0, count=0, overrun=0, rd/wr pointers=0, state=Init. rd_data undefined while empty.
- Handshake FSM states: Init, Arm, Ack, Hold.
  - Init: next cycle urx_go<=1, ->Arm (go first high 1 cycle after reset release).
  - Arm (urx_go=1): on urx_data_ready=1: if write permitted, store urx_data at wr_ptr; urx_go<=0; ->Ack. Capture latency: byte visible on rd_data/count 1 cycle after urx_data_ready sampled high.
  - Ack (urx_go=0): wait for urx_data_ready=0; then if FIFO full (after this cycle's pop considered) and drop mode off ->Hold, else urx_go<=1, ->Arm.
  - Hold (urx_go=0): wait until full=0 at clock edge; then urx_go<=1, ->Arm.
- Write permitted = !full || rd_en (simultaneous pop frees the slot; both happen, count unchanged).
- Read: rd_en with empty=1 ignored (no pointer move, no count underflow). rd_en with empty=0 advances rd_ptr; rd_data updates next cycle.
- Pointers DepthLog2 bits, wrap modulo depth; count = writes - reads, saturates never (guaranteed by guards). full = (count == 2**DepthLog2), empty = (count == 0), all registered/derived from registered state, no comb path from inputs to flags.
- clr_overrun: overrun<=0; if a drop occurs in the same cycle, set wins.
- Reset mid-operation: FIFO flushed, urx_go forced 0; receiver sees go low and returns to idle; no partial byte stored.

Optional Feature:
UART_RX_FIFO_DROP_EN
- Defined: Hold state unused; urx_go re-armed even when full. A byte arriving with full=1 and rd_en=0 is acknowledged normally but discarded; overrun<=1.
- Undefined: flow control via Hold (receiver kept disarmed while full; bytes on the line during Hold are not received). overrun never sets, tied 0; clr_overrun ignored.

Test Plan:
- Reset release -> urx_go=0 during reset, 1 exactly one cycle after rst_n=1; empty=1, count=0.
- Receiver model delivers 0x55 -> urx_go drops next cycle; next cycle count=1, rd_data=0x55; go re-raised after data_ready falls.
- Deliver 0x00..0x0F (DepthLog2=4) without reads -> full=1, count=16; pop all -> values 0x00..0x0F in order, empty=1 after 16th pop; rd_en while empty leaves count=0.
- Full FIFO, byte 0xA5 arrives same cycle as rd_en -> byte stored, count stays 16, head advances; wrap-around ordering preserved over 40 bytes.
- Full, no reads: without macro urx_go stays 0 (Hold) until one pop, then 1; with UART_RX_FIFO_DROP_EN byte 0x3C dropped, overrun=1, contents unchanged, clr_overrun -> overrun=0.
- Assert rst_n=0 while in Ack with count=5 -> next edge count=0, empty=1, urx_go=0, overrun=0.
